// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory responder slice: FSM state encoding,
// initiator port ids, word width and a helper for byte-offset detection.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Identifies which initiator owns the transaction in flight.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // True when a byte address does not point at the start of a word.
    function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Bundles the fetch port (i_*), the data port (d_*) and the busy flag shared
// between the CPU-side initiators and the memory responder.
//   master : CPU side - drives requests, receives acks/read data/busy
//   slave  : responder side - receives requests, drives acks/read data/busy
// Optional: MEM_MISALIGN_ERR_EN adds the err flag (pulses with the ack of an
// access whose byte address is not word aligned).
// -----------------------------------------------------------------------------
interface mem_responder_if;
    import mem_pkg::*;

    logic              i_req;
    logic [WORD_W-1:0] i_addr;
    logic              i_ack;
    logic [WORD_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              d_ack;
    logic [WORD_W-1:0] d_rdata;

    logic              busy;

`ifdef MEM_MISALIGN_ERR_EN
    logic              err;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_ack, i_rdata, d_ack, d_rdata, busy, err
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_ack, i_rdata, d_ack, d_rdata, busy, err
    );
`else
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_ack, i_rdata, d_ack, d_rdata, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_ack, i_rdata, d_ack, d_rdata, busy
    );
`endif

endinterface

// File: rtl/mem_responder_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port synchronous word RAM. One access per enabled clock edge; a write
// also returns the written word on rdata (write-first), so a store can echo
// its data through the same read path as a load.
// Ports:
//   clk   in  clock
//   en    in  access enable for this edge
//   we    in  1 = write wdata to addr, 0 = read addr
//   addr  in  word index
//   wdata in  write data
//   rdata out registered read (or echoed write) data
// -----------------------------------------------------------------------------
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // NOTE: the storage array has no reset branch; clearing it would turn the
    // RAM into a huge register file, and its contents must survive rst anyway.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
                rdata       <= wdata;
            end else begin
                rdata       <= r_mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the pipelined CPU. Serves the instruction-fetch
// port and the data port from one shared single-port RAM using a req/ack
// handshake with WAIT extra wait cycles per access. The data port wins a
// simultaneous request; the loser stays pending until the next IDLE.
// Ports:
//   clk  in     system clock
//   rst  in     asynchronous active-low reset
//   bus  slave  mem_responder_if (i_* fetch port, d_* data port, busy[, err])
// Parameters: DEPTH (words, power of two), AW (= log2(DEPTH)), WAIT (0..15).
// Optional: MEM_MISALIGN_ERR_EN - accesses with addr[1:0] != 0 complete with
// normal timing but skip the write, return zero and pulse err with the ack.
// -----------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int WAIT  = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t            r_state;
    logic [3:0]        r_cnt;
    port_t             r_port;
    logic              r_we;
    logic [AW-1:0]     r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic              r_i_ack;
    logic              r_d_ack;
    logic              r_busy;
    logic [WORD_W-1:0] r_i_rdata;
    logic [WORD_W-1:0] r_d_rdata;

    logic              w_access;
    logic              w_arr_we;
    logic [WORD_W-1:0] w_arr_rdata;
    logic [WORD_W-1:0] w_resp_word;

    // The single RAM access happens on the edge that leaves ACCESS.
    assign w_access = (r_state == ST_ACCESS) && (r_cnt == 4'd0);

`ifdef MEM_MISALIGN_ERR_EN
    logic r_misalign;
    logic r_err;

    assign w_arr_we    = r_we && !r_misalign;
    assign w_resp_word = r_misalign ? ZERO_WORD : w_arr_rdata;
    assign bus.err     = r_err;

    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{bus.i_addr[WORD_W-1:AW+2],
                                  bus.d_addr[WORD_W-1:AW+2]};
`else
    assign w_arr_we    = r_we;
    assign w_resp_word = w_arr_rdata;

    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{bus.i_addr[WORD_W-1:AW+2], bus.i_addr[1:0],
                                  bus.d_addr[WORD_W-1:AW+2], bus.d_addr[1:0]};
`endif

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (w_access),
        .we    (w_arr_we),
        .addr  (r_idx),
        .wdata (r_wdata),
        .rdata (w_arr_rdata)
    );

    // The RAM output register already holds the access result during RESP,
    // so the granted port shows it directly while its ack is high; the hold
    // registers capture it on the way out of RESP and keep it afterwards.
    assign bus.i_ack   = r_i_ack;
    assign bus.d_ack   = r_d_ack;
    assign bus.busy    = r_busy;
    assign bus.i_rdata = r_i_ack ? w_resp_word : r_i_rdata;
    assign bus.d_rdata = r_d_ack ? w_resp_word : r_d_rdata;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_port    <= PORT_I;
            r_we      <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= ZERO_WORD;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_busy    <= 1'b0;
            r_i_rdata <= ZERO_WORD;
            r_d_rdata <= ZERO_WORD;
`ifdef MEM_MISALIGN_ERR_EN
            r_misalign <= 1'b0;
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Data port has priority: it carries the older instruction.
                    if (bus.d_req) begin
                        r_port  <= PORT_D;
                        r_we    <= bus.d_we;
                        r_idx   <= bus.d_addr[AW+1:2];
                        r_wdata <= bus.d_wdata;
                        r_cnt   <= WAIT_CNT;
                        r_busy  <= 1'b1;
                        r_state <= ST_ACCESS;
`ifdef MEM_MISALIGN_ERR_EN
                        r_misalign <= is_misaligned(bus.d_addr);
`endif
                    end else if (bus.i_req) begin
                        r_port  <= PORT_I;
                        r_we    <= 1'b0;
                        r_idx   <= bus.i_addr[AW+1:2];
                        r_cnt   <= WAIT_CNT;
                        r_busy  <= 1'b1;
                        r_state <= ST_ACCESS;
`ifdef MEM_MISALIGN_ERR_EN
                        r_misalign <= is_misaligned(bus.i_addr);
`endif
                    end
                end

                ST_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= ST_RESP;
                        if (r_port == PORT_D) begin
                            r_d_ack <= 1'b1;
                        end else begin
                            r_i_ack <= 1'b1;
                        end
`ifdef MEM_MISALIGN_ERR_EN
                        r_err <= r_misalign;
`endif
                    end
                end

                ST_RESP: begin
                    if (r_i_ack) begin
                        r_i_rdata <= w_resp_word;
                    end
                    if (r_d_ack) begin
                        r_d_rdata <= w_resp_word;
                    end
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
`ifdef MEM_MISALIGN_ERR_EN
                    r_err <= 1'b0;
`endif
                end

                default: begin
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder. Three instances share clk/rst:
//   u_dut0 (WAIT=0) fetch stream, u_dut1 (WAIT=1) main table and corner
//   sequences, u_dut3 (WAIT=3) reset in the middle of a store.
// Build with MEM_MISALIGN_ERR_EN defined to exercise the err flag.
// -----------------------------------------------------------------------------
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();
    mem_responder_if bus3 ();

    mem_responder #(.DEPTH(1024), .AW(10), .WAIT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mem_responder #(.DEPTH(1024), .AW(10), .WAIT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mem_responder #(.DEPTH(1024), .AW(10), .WAIT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int tests = 0;
    int fails = 0;
    int both_acks = 0;

    // Expected held read data of u_dut1's two ports.
    logic [31:0] exp_i_hold;
    logic [31:0] exp_d_hold;
    logic        last_err;

    typedef struct {
        string       name;
        bit          port_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    always @(negedge clk) begin
        if (bus0.i_ack && bus0.d_ack) both_acks++;
        if (bus1.i_ack && bus1.d_ack) both_acks++;
        if (bus3.i_ack && bus3.d_ack) both_acks++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_bus0();
        bus0.i_req = 0; bus0.i_addr = '0; bus0.d_req = 0; bus0.d_we = 0; bus0.d_addr = '0; bus0.d_wdata = '0;
    endtask
    task automatic idle_bus1();
        bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
    endtask
    task automatic idle_bus3();
        bus3.i_req = 0; bus3.i_addr = '0; bus3.d_req = 0; bus3.d_we = 0; bus3.d_addr = '0; bus3.d_wdata = '0;
    endtask

    // One transaction on u_dut1; inputs are scrambled after the grant edge to
    // prove the responder works from its latched copy.
    task automatic xact1(input bit port_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
        bit got;
        @(negedge clk);
        if (port_d) begin
            bus1.d_req = 1; bus1.d_we = we; bus1.d_addr = addr; bus1.d_wdata = wdata;
        end else begin
            bus1.i_req = 1; bus1.i_addr = addr;
        end
        lat = 0; got = 0; rdata = 'x; last_err = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1; lat++;
            if (lat == 1) begin
                if (port_d) begin
                    bus1.d_addr = ~addr; bus1.d_wdata = ~wdata; bus1.d_we = ~we;
                end else begin
                    bus1.i_addr = ~addr;
                end
            end
            if (port_d ? bus1.d_ack : bus1.i_ack) begin
                rdata = port_d ? bus1.d_rdata : bus1.i_rdata;
`ifdef MEM_MISALIGN_ERR_EN
                last_err = bus1.err;
`endif
                got = 1;
                break;
            end
        end
        if (!got) lat = 99;
        if (port_d) bus1.d_req = 0; else bus1.i_req = 0;
        @(posedge clk); #1;
    endtask

    task automatic store0(input logic [31:0] addr, input logic [31:0] data);
        bit got = 0;
        @(negedge clk);
        bus0.d_req = 1; bus0.d_we = 1; bus0.d_addr = addr; bus0.d_wdata = data;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            if (bus0.d_ack) got = 1;
        end
        check("store0 ack", 32'(got), 32'd1);
        bus0.d_req = 0;
        @(posedge clk); #1;
    endtask

    task automatic store3(input logic [31:0] addr, input logic [31:0] data);
        int lat = 0;
        bit got = 0;
        @(negedge clk);
        bus3.d_req = 1; bus3.d_we = 1; bus3.d_addr = addr; bus3.d_wdata = data;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1; lat++;
            if (bus3.d_ack) got = 1;
        end
        check("store3 latency", 32'(lat), 32'd5);
        bus3.d_req = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        int d_at, i_at;
        logic [31:0] d_val, i_val;
        int ack_cyc [3];
        logic [31:0] ack_dat [3];
        int n;

        vecs[0] = '{"store 0x10",       1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{"load 0x10",        1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[2] = '{"store 0x4",        1'b1, 1'b1, 32'h0000_0004, 32'h1234_5678, 32'h1234_5678};
        vecs[3] = '{"load wrap 0x1004", 1'b1, 1'b0, 32'h0000_1004, 32'h0000_0000, 32'h1234_5678};
        vecs[4] = '{"fetch 0x10",       1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[5] = '{"store 0xFFC",      1'b1, 1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vecs[6] = '{"fetch 0xFFFFFFFC", 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hA5A5_A5A5};
        vecs[7] = '{"store 0x20",       1'b1, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0BAD_F00D};
        vecs[8] = '{"fetch 0x4",        1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h1234_5678};

        idle_bus0(); idle_bus1(); idle_bus3();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",    32'(bus1.busy),  32'd0);
        check("reset i_ack",   32'(bus1.i_ack), 32'd0);
        check("reset d_ack",   32'(bus1.d_ack), 32'd0);
        check("reset i_rdata", bus1.i_rdata,    32'h0);
        check("reset d_rdata", bus1.d_rdata,    32'h0);
        @(negedge clk) rst = 1'b1;
        exp_i_hold = 32'h0;
        exp_d_hold = 32'h0;

        // Table-driven transactions on the WAIT=1 instance.
        for (int v = 0; v < 9; v++) begin
            xact1(vecs[v].port_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, lat);
            check({vecs[v].name, " data"}, rd, vecs[v].exp);
            check({vecs[v].name, " latency"}, 32'(lat), 32'd3);
            if (vecs[v].port_d) exp_d_hold = vecs[v].exp; else exp_i_hold = vecs[v].exp;
            check({vecs[v].name, " i_rdata hold"}, bus1.i_rdata, exp_i_hold);
            check({vecs[v].name, " d_rdata hold"}, bus1.d_rdata, exp_d_hold);
            check({vecs[v].name, " busy idle"}, 32'(bus1.busy), 32'd0);
        end

        // Misaligned store to 0x21 followed by a load of 0x20.
`ifdef MEM_MISALIGN_ERR_EN
        xact1(1'b1, 1'b1, 32'h0000_0021, 32'hAAAA_5555, rd, lat);
        check("misalign store data", rd, 32'h0);
        check("misalign store err", 32'(last_err), 32'd1);
        check("misalign store latency", 32'(lat), 32'd3);
        xact1(1'b1, 1'b0, 32'h0000_0020, 32'h0, rd, lat);
        check("misalign reload data", rd, 32'h0BAD_F00D);
        check("misalign reload err", 32'(last_err), 32'd0);
        check("err idle", 32'(bus1.err), 32'd0);
`else
        xact1(1'b1, 1'b1, 32'h0000_0021, 32'hAAAA_5555, rd, lat);
        check("offset store echo", rd, 32'hAAAA_5555);
        xact1(1'b1, 1'b0, 32'h0000_0020, 32'h0, rd, lat);
        check("offset ignored reload", rd, 32'hAAAA_5555);
`endif

        // Simultaneous requests: data port first, fetch WAIT+3 cycles later.
        @(negedge clk);
        bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 32'h10;
        bus1.i_req = 1; bus1.i_addr = 32'h4;
        d_at = 0; i_at = 0; d_val = 'x; i_val = 'x;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (bus1.d_ack) begin d_at = cyc; d_val = bus1.d_rdata; bus1.d_req = 0; end
            if (bus1.i_ack) begin i_at = cyc; i_val = bus1.i_rdata; bus1.i_req = 0; end
            if (d_at != 0 && i_at != 0) break;
        end
        bus1.d_req = 0; bus1.i_req = 0;
        @(posedge clk); #1;
        check("simul d_ack cycle", 32'(d_at), 32'd3);
        check("simul i_ack cycle", 32'(i_at), 32'd7);
        check("simul d data", d_val, 32'hDEAD_BEEF);
        check("simul i data", i_val, 32'h1234_5678);

        // WAIT=0 fetch stream over three preloaded words.
        store0(32'h0, 32'h1000_0001);
        store0(32'h4, 32'h2000_0002);
        store0(32'h8, 32'h3000_0003);
        @(negedge clk);
        bus0.i_req = 1; bus0.i_addr = 32'h0;
        n = 0;
        for (int cyc = 1; cyc <= 30 && n < 3; cyc++) begin
            @(posedge clk); #1;
            if (bus0.i_ack) begin
                ack_cyc[n] = cyc; ack_dat[n] = bus0.i_rdata; n++;
                bus0.i_addr = 32'(4 * n);
                if (n == 3) bus0.i_req = 0;
            end
        end
        bus0.i_req = 0;
        @(posedge clk); #1;
        check("stream ack count", 32'(n), 32'd3);
        if (n == 3) begin
            check("stream first ack", 32'(ack_cyc[0]), 32'd2);
            check("stream gap 0-1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
            check("stream gap 1-2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);
            check("stream word 0", ack_dat[0], 32'h1000_0001);
            check("stream word 1", ack_dat[1], 32'h2000_0002);
            check("stream word 2", ack_dat[2], 32'h3000_0003);
        end

        // Reset during ACCESS of a store (WAIT=3): the write must not land.
        store3(32'h40, 32'h1111_1111);
        @(negedge clk);
        bus3.d_req = 1; bus3.d_we = 1; bus3.d_addr = 32'h40; bus3.d_wdata = 32'h55;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midop busy before reset", 32'(bus3.busy), 32'd1);
        rst = 1'b0;
        #1;
        check("midop d_ack", 32'(bus3.d_ack), 32'd0);
        check("midop busy", 32'(bus3.busy), 32'd0);
        check("midop d_rdata", bus3.d_rdata, 32'h0);
        check("midop other dut i_rdata", bus1.i_rdata, 32'h0);
        bus3.d_req = 0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        bus3.i_req = 1; bus3.i_addr = 32'h40;
        lat = 0; rd = 'x;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1; lat++;
            if (bus3.i_ack) begin rd = bus3.i_rdata; break; end
        end
        bus3.i_req = 0;
        @(posedge clk); #1;
        check("midop reload data", rd, 32'h1111_1111);
        check("midop reload latency", 32'(lat), 32'd5);

        check("acks never concurrent", 32'(both_acks), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
